// File: rtl/ode_io_phase_controller.sv
// Phase sequencer for the ODE solver: load -> start -> solve, and send on request.
// Owns the shared RAM port mux and a per-phase watchdog.
module ode_io_phase_controller #(
  parameter int ADDRESS_WIDTH  = 13,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMER_WIDTH    = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     INT,
  input  logic                     Load_Process,
  input  logic                     Done_Loading,
  input  logic                     Solver_Done,
  input  logic                     Done_Sending,
  input  logic                     IO_WR_Enable,
  input  logic [ADDRESS_WIDTH-1:0] IO_Address_WR,
  input  logic [DATA_WIDTH-1:0]    IO_Data_WR,
  input  logic                     Solver_WR_Enable,
  input  logic [ADDRESS_WIDTH-1:0] Solver_Address_WR,
  input  logic [DATA_WIDTH-1:0]    Solver_Data_WR,
  input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_A,
  input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_B,
  input  logic [ADDRESS_WIDTH-1:0] Sender_Address_RD_A,
  input  logic [ADDRESS_WIDTH-1:0] Sender_Address_RD_B,
  output logic                     RAM_WR_Enable,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address_WR,
  output logic [DATA_WIDTH-1:0]    RAM_Data_WR,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B,
  output logic                     Loading_Enable,
  output logic                     Solver_Start,
  output logic                     Sending_Enable,
  output logic                     Done_Processing,
  output logic                     Timeout_Error,
  output logic [2:0]               Phase
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_SOLVE = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    TIMER_WIDTH'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   expired;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign expired = WDOG_EN && (timer_q == TIMER_LAST);

  // A done pulse in the expiry cycle takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (INT && Load_Process) begin
          state_d = S_LOAD;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (INT && done_q) begin
          state_d = S_SEND;
        end
      end
      S_LOAD: begin
        if (Done_Loading) begin
          state_d = S_START;
        end else if (expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_START: state_d = S_SOLVE;
      S_SOLVE: begin
        if (Solver_Done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_SEND: begin
        if (Done_Sending) begin
          state_d = S_IDLE;
        end else if (expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == S_LOAD || state_q == S_SOLVE || state_q == S_SEND) begin
      timer_d = timer_q + TIMER_WIDTH'(1);
    end else begin
      timer_d = '0;
    end
  end

  // Strobes and RAM mux decode from the registered state only.
  always_comb begin
    RAM_WR_Enable    = 1'b0;
    RAM_Address_WR   = '0;
    RAM_Data_WR      = '0;
    RAM_Address_RD_A = '0;
    RAM_Address_RD_B = '0;
    Loading_Enable   = 1'b0;
    Solver_Start     = 1'b0;
    Sending_Enable   = 1'b0;
    case (state_q)
      S_LOAD: begin
        Loading_Enable = 1'b1;
        RAM_WR_Enable  = IO_WR_Enable;
        RAM_Address_WR = IO_Address_WR;
        RAM_Data_WR    = IO_Data_WR;
      end
      S_START, S_SOLVE: begin
        Solver_Start     = (state_q == S_START);
        RAM_WR_Enable    = Solver_WR_Enable;
        RAM_Address_WR   = Solver_Address_WR;
        RAM_Data_WR      = Solver_Data_WR;
        RAM_Address_RD_A = Solver_Address_RD_A;
        RAM_Address_RD_B = Solver_Address_RD_B;
      end
      S_SEND: begin
        Sending_Enable   = 1'b1;
        RAM_Address_RD_A = Sender_Address_RD_A;
        RAM_Address_RD_B = Sender_Address_RD_B;
      end
      default: ;
    endcase
  end

  assign Done_Processing = done_q;
  assign Timeout_Error   = err_q;
  assign Phase           = state_q;

endmodule

// File: tb/tb_ode_io_phase_controller.sv
// Self-checking bench for ode_io_phase_controller: directed scenarios plus a
// randomized run compared against a rule-level reference model.
module tb_ode_io_phase_controller;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int TO = 8;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          int_i, load_proc, done_loading, solver_done, done_sending;
  logic          io_we, sv_we;
  logic [AW-1:0] io_aw, sv_aw, sv_ra, sv_rb, sd_ra, sd_rb;
  logic [DW-1:0] io_dw, sv_dw;
  logic          ram_we, load_en, solver_start, send_en, done_proc, timeout_err;
  logic [AW-1:0] ram_aw, ram_ra, ram_rb;
  logic [DW-1:0] ram_dw;
  logic [2:0]    phase;

  int n_cmp = 0;
  int n_mis = 0;

  ode_io_phase_controller #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TIMER_WIDTH(TW)
  ) dut (
    .CLK(clk), .RST(rst), .INT(int_i), .Load_Process(load_proc),
    .Done_Loading(done_loading), .Solver_Done(solver_done), .Done_Sending(done_sending),
    .IO_WR_Enable(io_we), .IO_Address_WR(io_aw), .IO_Data_WR(io_dw),
    .Solver_WR_Enable(sv_we), .Solver_Address_WR(sv_aw), .Solver_Data_WR(sv_dw),
    .Solver_Address_RD_A(sv_ra), .Solver_Address_RD_B(sv_rb),
    .Sender_Address_RD_A(sd_ra), .Sender_Address_RD_B(sd_rb),
    .RAM_WR_Enable(ram_we), .RAM_Address_WR(ram_aw), .RAM_Data_WR(ram_dw),
    .RAM_Address_RD_A(ram_ra), .RAM_Address_RD_B(ram_rb),
    .Loading_Enable(load_en), .Solver_Start(solver_start), .Sending_Enable(send_en),
    .Done_Processing(done_proc), .Timeout_Error(timeout_err), .Phase(phase)
  );

  // Reference model: phase number, results flag, error flag, cycles spent in phase.
  int m_phase = 0;
  int m_nxt;
  int m_cnt = 0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  bit m_done_nxt, m_err_nxt, m_hit;

  always_comb begin
    m_nxt      = m_phase;
    m_done_nxt = m_done;
    m_err_nxt  = m_err;
    m_hit      = (TO != 0) && (m_phase == 1 || m_phase == 3 || m_phase == 4) && (m_cnt + 1 == TO);
    case (m_phase)
      0: if (int_i && load_proc) begin m_nxt = 1; m_done_nxt = 1'b0; m_err_nxt = 1'b0; end
         else if (int_i && m_done) m_nxt = 4;
      1: if (done_loading) m_nxt = 2;
         else if (m_hit) begin m_nxt = 0; m_err_nxt = 1'b1; end
      2: m_nxt = 3;
      3: if (solver_done) begin m_nxt = 0; m_done_nxt = 1'b1; end
         else if (m_hit) begin m_nxt = 0; m_err_nxt = 1'b1; end
      4: if (done_sending) m_nxt = 0;
         else if (m_hit) begin m_nxt = 0; m_err_nxt = 1'b1; end
      default: m_nxt = 0;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_done  <= 1'b0;
      m_err   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      m_phase <= m_nxt;
      m_done  <= m_done_nxt;
      m_err   <= m_err_nxt;
      m_cnt   <= (m_nxt != m_phase) ? 0 : m_cnt + 1;
    end
  end

  // Expected RAM port contents: whichever requester owns the current phase.
  logic          exp_we;
  logic [AW-1:0] exp_aw, exp_ra, exp_rb;
  logic [DW-1:0] exp_dw;
  always_comb begin
    exp_we = 1'b0; exp_aw = '0; exp_dw = '0; exp_ra = '0; exp_rb = '0;
    if (m_phase == 1) begin
      exp_we = io_we; exp_aw = io_aw; exp_dw = io_dw;
    end else if (m_phase == 2 || m_phase == 3) begin
      exp_we = sv_we; exp_aw = sv_aw; exp_dw = sv_dw; exp_ra = sv_ra; exp_rb = sv_rb;
    end else if (m_phase == 4) begin
      exp_ra = sd_ra; exp_rb = sd_rb;
    end
  end

  task automatic clear_inputs();
    int_i = 0; load_proc = 0; done_loading = 0; solver_done = 0; done_sending = 0;
    io_we = 0; sv_we = 0; io_aw = '0; sv_aw = '0; sv_ra = '0; sv_rb = '0;
    sd_ra = '0; sd_rb = '0; io_dw = '0; sv_dw = '0;
  endtask

  task automatic rand_data();
    io_we = 1'($urandom); sv_we = 1'($urandom);
    io_aw = AW'($urandom); sv_aw = AW'($urandom); sv_ra = AW'($urandom);
    sv_rb = AW'($urandom); sd_ra = AW'($urandom); sd_rb = AW'($urandom);
    io_dw = {$urandom, $urandom}; sv_dw = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    clear_inputs();
    rand_data();
    io_we = 1; sv_we = 1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (phase !== 3'd0) begin n_mis++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    n_cmp++; if ({ram_we, ram_aw, ram_dw, ram_ra, ram_rb} !== '0) begin n_mis++; $display("FAIL reset_ram got=%0b/%0h/%0h/%0h/%0h exp=0", ram_we, ram_aw, ram_dw, ram_ra, ram_rb); end
    n_cmp++; if ({done_proc, timeout_err, load_en, solver_start, send_en} !== 5'b0) begin n_mis++; $display("FAIL reset_flags got=%b exp=00000", {done_proc, timeout_err, load_en, solver_start, send_en}); end
    @(negedge clk); rst = 0; clear_inputs();
    // Drive into SOLVE, then hit reset asynchronously mid-cycle.
    int_i = 1; load_proc = 1;
    @(negedge clk); int_i = 0; load_proc = 0; done_loading = 1;
    @(negedge clk); done_loading = 0;
    @(negedge clk); rand_data(); sv_we = 1; #1;
    n_cmp++; if (phase !== 3'd3) begin n_mis++; $display("FAIL rst_pre_solve got=%0d exp=3", phase); end
    #1 rst = 1; #1;
    n_cmp++; if (phase !== 3'd0) begin n_mis++; $display("FAIL rst_async_phase got=%0d exp=0", phase); end
    n_cmp++; if ({ram_we, ram_aw, ram_dw, ram_ra, ram_rb} !== '0) begin n_mis++; $display("FAIL rst_async_ram got=%0b/%0h/%0h exp=0", ram_we, ram_aw, ram_dw); end
    n_cmp++; if (done_proc !== 1'b0) begin n_mis++; $display("FAIL rst_async_done got=%0b exp=0", done_proc); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (solver_start !== 1'b0 || phase !== 3'd0) begin n_mis++; $display("FAIL rst_release start=%0b phase=%0d exp=0/0", solver_start, phase); end
    end
    clear_inputs();
    $display("test_reset done");
  endtask

  task automatic test_load_solve();
    @(negedge clk); int_i = 1; load_proc = 1;
    @(negedge clk); int_i = 0; load_proc = 0; #1;
    n_cmp++; if (load_en !== 1'b1 || phase !== 3'd1) begin n_mis++; $display("FAIL load_enter en=%0b phase=%0d exp=1/1", load_en, phase); end
    io_we = 1; io_aw = AW'(5); io_dw = 64'hABCD; #1;
    n_cmp++; if (ram_we !== 1'b1 || ram_aw !== AW'(5) || ram_dw !== 64'hABCD) begin n_mis++; $display("FAIL load_write got=%0b/%0h/%0h exp=1/5/abcd", ram_we, ram_aw, ram_dw); end
    n_cmp++; if (ram_ra !== '0 || ram_rb !== '0) begin n_mis++; $display("FAIL load_reads got=%0h/%0h exp=0/0", ram_ra, ram_rb); end
    @(negedge clk); io_we = 0; done_loading = 1;
    @(negedge clk); done_loading = 0; #1;
    n_cmp++; if (solver_start !== 1'b1 || phase !== 3'd2) begin n_mis++; $display("FAIL start_pulse got=%0b phase=%0d exp=1/2", solver_start, phase); end
    @(negedge clk); sv_ra = AW'(3); #1;
    n_cmp++; if (solver_start !== 1'b0 || phase !== 3'd3) begin n_mis++; $display("FAIL start_once got=%0b phase=%0d exp=0/3", solver_start, phase); end
    n_cmp++; if (ram_ra !== AW'(3)) begin n_mis++; $display("FAIL solve_read got=%0h exp=3", ram_ra); end
    solver_done = 1;
    @(negedge clk); solver_done = 0; #1;
    n_cmp++; if (phase !== 3'd0 || done_proc !== 1'b1) begin n_mis++; $display("FAIL solve_exit phase=%0d done=%0b exp=0/1", phase, done_proc); end
    clear_inputs();
    $display("test_load_solve done");
  endtask

  task automatic test_send();
    @(negedge clk); int_i = 1; load_proc = 0;
    @(negedge clk); int_i = 0; #1;
    n_cmp++; if (send_en !== 1'b1 || phase !== 3'd4) begin n_mis++; $display("FAIL send_enter en=%0b phase=%0d exp=1/4", send_en, phase); end
    sd_ra = AW'(7); io_we = 1; sv_we = 1; io_aw = AW'(9); io_dw = 64'h55; #1;
    n_cmp++; if (ram_ra !== AW'(7)) begin n_mis++; $display("FAIL send_read got=%0h exp=7", ram_ra); end
    n_cmp++; if (ram_we !== 1'b0 || ram_aw !== '0 || ram_dw !== '0) begin n_mis++; $display("FAIL send_nowrite got=%0b/%0h/%0h exp=0/0/0", ram_we, ram_aw, ram_dw); end
    @(negedge clk); io_we = 0; sv_we = 0; done_sending = 1;
    @(negedge clk); done_sending = 0; #1;
    n_cmp++; if (phase !== 3'd0 || done_proc !== 1'b1 || send_en !== 1'b0) begin n_mis++; $display("FAIL send_exit phase=%0d done=%0b en=%0b exp=0/1/0", phase, done_proc, send_en); end
    clear_inputs();
    $display("test_send done");
  endtask

  task automatic test_send_before_results();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; int_i = 1; load_proc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (phase !== 3'd0 || send_en !== 1'b0) begin n_mis++; $display("FAIL early_send phase=%0d en=%0b exp=0/0", phase, send_en); end
    end
    clear_inputs();
    $display("test_send_before_results done");
  endtask

  task automatic test_watchdog();
    @(negedge clk); int_i = 1; load_proc = 1;
    @(negedge clk); int_i = 0; load_proc = 0;
    for (int k = 1; k <= TO; k++) begin
      #1;
      n_cmp++; if (phase !== 3'd1 || timeout_err !== 1'b0) begin n_mis++; $display("FAIL wdog_hold cyc=%0d phase=%0d err=%0b exp=1/0", k, phase, timeout_err); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (phase !== 3'd0 || timeout_err !== 1'b1) begin n_mis++; $display("FAIL wdog_fire phase=%0d err=%0b exp=0/1", phase, timeout_err); end
    @(negedge clk); int_i = 1; load_proc = 1;
    @(negedge clk); int_i = 0; load_proc = 0; #1;
    n_cmp++; if (timeout_err !== 1'b0 || phase !== 3'd1) begin n_mis++; $display("FAIL wdog_clear err=%0b phase=%0d exp=0/1", timeout_err, phase); end
    repeat (TO - 1) @(negedge clk);
    done_loading = 1;
    @(negedge clk); done_loading = 0; #1;
    n_cmp++; if (phase !== 3'd2 || timeout_err !== 1'b0) begin n_mis++; $display("FAIL wdog_race phase=%0d err=%0b exp=2/0", phase, timeout_err); end
    @(negedge clk); solver_done = 1;
    @(negedge clk); clear_inputs();
    $display("test_watchdog done");
  endtask

  task automatic test_isolation();
    @(negedge clk); int_i = 1; load_proc = 1;
    @(negedge clk); clear_inputs(); rand_data(); io_we = 0; sv_we = 1; #1;
    n_cmp++; if (ram_we !== 1'b0 || ram_aw !== io_aw) begin n_mis++; $display("FAIL iso_load_sv we=%0b aw=%0h exp=0/%0h", ram_we, ram_aw, io_aw); end
    io_we = 1; #1;
    n_cmp++; if (ram_we !== 1'b1 || ram_aw !== io_aw || ram_dw !== io_dw) begin n_mis++; $display("FAIL iso_load_io got=%0b/%0h/%0h exp=1/%0h/%0h", ram_we, ram_aw, ram_dw, io_aw, io_dw); end
    @(negedge clk); io_we = 0; sv_we = 0; done_loading = 1;
    @(negedge clk); done_loading = 0;
    @(negedge clk); rand_data(); io_we = 1; sv_we = 0; #1;
    n_cmp++; if (ram_we !== 1'b0 || ram_aw !== sv_aw || ram_dw !== sv_dw) begin n_mis++; $display("FAIL iso_solve_io got=%0b/%0h/%0h exp=0/%0h/%0h", ram_we, ram_aw, ram_dw, sv_aw, sv_dw); end
    sv_we = 1; #1;
    n_cmp++; if (ram_we !== 1'b1 || ram_rb !== sv_rb) begin n_mis++; $display("FAIL iso_solve_sv we=%0b rb=%0h exp=1/%0h", ram_we, ram_rb, sv_rb); end
    @(negedge clk); solver_done = 1;
    @(negedge clk); clear_inputs();
    $display("test_isolation done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 249) == 0);
      int_i        = ($urandom_range(0, 5) == 0);
      load_proc    = 1'($urandom);
      done_loading = ($urandom_range(0, 5) == 0);
      solver_done  = ($urandom_range(0, 5) == 0);
      done_sending = ($urandom_range(0, 5) == 0);
      rand_data();
      #1;
      n_cmp++; if (phase !== 3'(m_phase)) begin n_mis++; $display("FAIL rnd_phase c=%0d got=%0d exp=%0d", c, phase, m_phase); end
      n_cmp++; if ({load_en, solver_start, send_en} !== {m_phase == 1, m_phase == 2, m_phase == 4}) begin n_mis++; $display("FAIL rnd_strobes c=%0d got=%b phase=%0d", c, {load_en, solver_start, send_en}, m_phase); end
      n_cmp++; if (done_proc !== m_done || timeout_err !== m_err) begin n_mis++; $display("FAIL rnd_flags c=%0d got=%b%b exp=%b%b", c, done_proc, timeout_err, m_done, m_err); end
      n_cmp++; if ({ram_we, ram_aw, ram_dw, ram_ra, ram_rb} !== {exp_we, exp_aw, exp_dw, exp_ra, exp_rb}) begin n_mis++; $display("FAIL rnd_ram c=%0d got=%0b/%0h/%0h/%0h/%0h exp=%0b/%0h/%0h/%0h/%0h", c, ram_we, ram_aw, ram_dw, ram_ra, ram_rb, exp_we, exp_aw, exp_dw, exp_ra, exp_rb); end
    end
    @(negedge clk); rst = 1; clear_inputs();
    @(negedge clk); rst = 0;
    $display("test_random done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_solve();
    test_send();
    test_send_before_results();
    test_watchdog();
    test_isolation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
